// File: rtl/regfile_scan_master_pkg.sv
// Shared definitions for the register file scan master.
// Holds the controller state encoding, register file geometry and the
// command mode encoding used on the `mode` input.
`timescale 1ns/1ps
package regfile_scan_master_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_SEND = 3'd2,
    ST_LOAD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_scan_master.sv
// Register file scan master: dumps a contiguous, wrapping register range onto
// a valid/ready output stream, or loads such a range from a valid/ready input
// stream through the register file write port.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   start, mode             command strobe (IDLE only), 0 = dump, 1 = load
//   first_reg, last_reg     inclusive register range, wraps modulo 32
//   a1 / rd1                register file read address / read data
//   a3, wd3, sig_RegWrite   register file write port (registered)
//   out_data/valid/ready    dump stream
//   in_data/valid/ready     load stream
//   busy, done              command in progress / one-cycle completion pulse
`timescale 1ns/1ps
module regfile_scan_master
  import regfile_scan_master_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = REG_DW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [REG_AW-1:0] first_reg,
  input  logic [REG_AW-1:0] last_reg,
  output logic [REG_AW-1:0] a1,
  input  logic [DW-1:0]     rd1,
  output logic [REG_AW-1:0] a3,
  output logic [DW-1:0]     wd3,
  output logic              sig_RegWrite,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done
);

  // One extra bit so a full sweep of all NREG registers is representable.
  localparam int CNT_W = $clog2(NREG) + 1;

  state_t              state, state_n;
  logic [REG_AW-1:0]   idx;
  logic [CNT_W-1:0]    cnt;
  logic                last_word;
  logic                out_hs;
  logic                in_hs;

  // Inclusive wrapping range length: the 5-bit subtraction wraps naturally,
  // so first == last gives 1 and last == first-1 gives NREG.
  function automatic logic [CNT_W-1:0] range_count(input logic [REG_AW-1:0] first,
                                                   input logic [REG_AW-1:0] last);
    logic [REG_AW-1:0] diff;
    diff = last - first;
    return CNT_W'(diff) + CNT_W'(1);
  endfunction

  assign a1        = idx;
  assign last_word = (cnt == CNT_W'(1));
  assign out_hs    = out_valid && out_ready;
  assign in_hs     = in_valid && in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_n = (mode == MODE_DUMP) ? ST_RD : ST_LOAD;
      end
      ST_RD:   state_n = ST_SEND;
      ST_SEND: if (out_hs) state_n = last_word ? ST_DONE : ST_RD;
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) state_n = last_word ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      cnt          <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      a3           <= '0;
      wd3          <= '0;
      sig_RegWrite <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse per accepted word.
      sig_RegWrite <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx <= first_reg;
            cnt <= range_count(first_reg, last_reg);
          end
        end
        ST_RD: begin
          out_data  <= rd1;
          out_valid <= 1'b1;
        end
        ST_SEND: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            if (!last_word) begin
              idx <= idx + REG_AW'(1);
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        ST_LOAD: begin
          if (in_hs) begin
            a3           <= idx;
            wd3          <= in_data;
            // r0 is hardwired; its word is consumed but never written.
            sig_RegWrite <= (idx != '0);
            if (!last_word) begin
              idx <= idx + REG_AW'(1);
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
